// File: rtl/ram_arbiter_mc.sv
// ram_arbiter_mc: SRAM arbiter for NCH prioritised channels plus one background (video) reader.
// Define RAM_ARB_PREEMPT_EN to let channel requests abandon a background access in progress.
module ram_arbiter_mc #(
    parameter int AW         = 19,
    parameter int DW         = 8,
    parameter int NCH        = 2,
    parameter int LATENCY    = 2,
    parameter int LATENCY_BG = 1
) (
    input  logic              clk28,
    input  logic              rst,
    input  logic [NCH-1:0]    req_rd,
    input  logic [NCH-1:0]    req_wr,
    input  logic [NCH*AW-1:0] req_addr,
    input  logic [NCH*DW-1:0] req_wdata,
    output logic [NCH-1:0]    req_latchen,
    output logic [NCH-1:0]    req_valid,
    output logic [NCH-1:0]    req_restart,
    input  logic              bg_req,
    input  logic [AW-1:0]     bg_addr,
    output logic              bg_ack,
    output logic              bg_valid,
    output logic [AW-1:0]     va,
    output logic [DW-1:0]     vd_out,
    output logic              n_vrd,
    output logic              n_vwr
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {CUR_NONE, CUR_RD, CUR_BG} cur_t;

    cur_t            cur, cur_n;
    logic [CW-1:0]   cur_ch, cur_ch_n;
    logic [1:0]      step, step_n;
    logic [AW-1:0]   va_n, restart_addr;
    logic [DW-1:0]   vd_out_n;
    logic            n_vrd_n, n_vwr_n;
    logic [NCH-1:0]  latchen_n;
    logic [NCH-1:0]  rd_prev, wr_prev, rd_pend, wr_pend, rd_pend_n, wr_pend_n;
    logic [NCH-1:0]  rd_elig, wr_elig;
    logic            any_elig, preempt, grant_pt, restart_hit, found;

    assign rd_elig  = rd_pend | (req_rd & ~rd_prev);
    assign wr_elig  = wr_pend | (req_wr & ~wr_prev);
    assign any_elig = |{rd_elig, wr_elig};

`ifdef RAM_ARB_PREEMPT_EN
    assign preempt = (cur == CUR_BG) && any_elig;
`else
    assign preempt = 1'b0;
`endif

    assign grant_pt = (step == 2'd0) || preempt;
    assign bg_valid = (cur == CUR_BG) && (step == 2'd0);
    // Without preemption the background access always completes, so its address is always consumed.
    assign bg_ack   = (cur == CUR_BG) && (step == 2'd1) && !preempt;

    always_comb begin
        req_valid    = '0;
        req_restart  = '0;
        restart_addr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cur == CUR_RD && cur_ch == CW'(i)) begin
                req_valid[i]   = (step == 2'd0);
                req_restart[i] = (req_addr[i*AW +: AW] != va);
                restart_addr   = req_addr[i*AW +: AW];
            end
        end
        restart_hit = |req_restart;
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        cur_n     = cur;
        cur_ch_n  = cur_ch;
        step_n    = step;
        va_n      = va;
        vd_out_n  = vd_out;
        n_vrd_n   = n_vrd;
        n_vwr_n   = n_vwr;
        latchen_n = req_latchen;
        rd_pend_n = rd_elig & req_rd;
        wr_pend_n = wr_elig & req_wr;
        found     = 1'b0;

        if (restart_hit) begin
            va_n   = restart_addr;
            step_n = 2'(LATENCY);
        end else if (grant_pt) begin
            cur_n     = CUR_NONE;
            step_n    = 2'd0;
            n_vrd_n   = 1'b1;
            n_vwr_n   = 1'b1;
            latchen_n = '0;
            for (int i = 0; i < NCH; i++) begin
                if (!found && wr_elig[i]) begin
                    found        = 1'b1;
                    n_vwr_n      = 1'b0;
                    va_n         = req_addr[i*AW +: AW];
                    vd_out_n     = req_wdata[i*DW +: DW];
                    step_n       = 2'(LATENCY);
                    wr_pend_n[i] = 1'b0;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (!found && rd_elig[i]) begin
                    found        = 1'b1;
                    n_vrd_n      = 1'b0;
                    va_n         = req_addr[i*AW +: AW];
                    cur_n        = CUR_RD;
                    cur_ch_n     = CW'(i);
                    latchen_n[i] = 1'b1;
                    step_n       = 2'(LATENCY);
                    rd_pend_n[i] = 1'b0;
                end
            end
            if (!found && bg_req) begin
                n_vrd_n = 1'b0;
                va_n    = bg_addr;
                cur_n   = CUR_BG;
                step_n  = 2'(LATENCY_BG);
            end
        end else begin
            step_n = step - 2'd1;
        end
    end

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk28) begin
        rd_prev <= req_rd;
        wr_prev <= req_wr;
        if (rst) begin
            cur         <= CUR_NONE;
            cur_ch      <= '0;
            step        <= 2'd0;
            va          <= '0;
            vd_out      <= '0;
            n_vrd       <= 1'b1;
            n_vwr       <= 1'b1;
            req_latchen <= '0;
            rd_pend     <= '0;
            wr_pend     <= '0;
        end else begin
            cur         <= cur_n;
            cur_ch      <= cur_ch_n;
            step        <= step_n;
            va          <= va_n;
            vd_out      <= vd_out_n;
            n_vrd       <= n_vrd_n;
            n_vwr       <= n_vwr_n;
            req_latchen <= latchen_n;
            rd_pend     <= rd_pend_n;
            wr_pend     <= wr_pend_n;
        end
    end
endmodule

// File: tb/tb_ram_arbiter_mc.sv
// tb_ram_arbiter_mc: directed scenarios plus random traffic against a transaction-level reference model.
// Honours RAM_ARB_PREEMPT_EN the same way the design does.
module tb_ram_arbiter_mc;
    localparam int AW = 19, DW = 8, NCH = 2, LAT = 2, LBG = 1;
`ifdef RAM_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    logic              clk28 = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req_rd, req_wr;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    req_latchen, req_valid, req_restart;
    logic              bg_req, bg_ack, bg_valid;
    logic [AW-1:0]     bg_addr, va;
    logic [DW-1:0]     vd_out;
    logic              n_vrd, n_vwr;

    always #5 clk28 = ~clk28;

    ram_arbiter_mc #(.AW(AW), .DW(DW), .NCH(NCH), .LATENCY(LAT), .LATENCY_BG(LBG)) dut (
        .clk28(clk28), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_latchen(req_latchen),
        .req_valid(req_valid), .req_restart(req_restart), .bg_req(bg_req),
        .bg_addr(bg_addr), .bg_ack(bg_ack), .bg_valid(bg_valid), .va(va),
        .vd_out(vd_out), .n_vrd(n_vrd), .n_vwr(n_vwr)
    );

    // Reference model: the access in flight is described by its owner and the cycles left.
    int             m_left;
    int             m_rd_ch;
    bit             m_bg;
    logic [AW-1:0]  m_va;
    logic [DW-1:0]  m_vd;
    logic           m_nrd, m_nwr;
    logic [NCH-1:0] m_latch, m_rd_pend, m_wr_pend, m_rd_prev, m_wr_prev;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return req_addr[i*AW +: AW];
    endfunction

    function automatic int first_set(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_left = 0; m_rd_ch = -1; m_bg = 0;
        m_va = '0; m_vd = '0; m_nrd = 1'b1; m_nwr = 1'b1;
        m_latch = '0; m_rd_pend = '0; m_wr_pend = '0;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    // Compare one cycle, advance the model across the coming edge, return at the next negedge.
    task automatic tick();
        logic [NCH-1:0] e_rd, e_wr, x_valid, x_restart;
        bit pre, x_bga, x_bgv;
        int ww, wr;
        #1;
        e_rd = m_rd_pend | (req_rd & ~m_rd_prev);
        e_wr = m_wr_pend | (req_wr & ~m_wr_prev);
        pre  = PREEMPT && m_bg && ((e_rd | e_wr) != '0);
        x_valid = '0; x_restart = '0;
        if (m_rd_ch >= 0) begin
            if (m_left == 0) x_valid[m_rd_ch] = 1'b1;
            if (addr_of(m_rd_ch) != m_va) x_restart[m_rd_ch] = 1'b1;
        end
        x_bgv = m_bg && (m_left == 0);
        x_bga = m_bg && (m_left == 1) && !pre;

        check("va", 32'(va), 32'(m_va));
        check("vd_out", 32'(vd_out), 32'(m_vd));
        check("n_vrd", 32'(n_vrd), 32'(m_nrd));
        check("n_vwr", 32'(n_vwr), 32'(m_nwr));
        check("req_latchen", 32'(req_latchen), 32'(m_latch));
        check("req_valid", 32'(req_valid), 32'(x_valid));
        check("req_restart", 32'(req_restart), 32'(x_restart));
        check("bg_ack", 32'(bg_ack), 32'(x_bga));
        check("bg_valid", 32'(bg_valid), 32'(x_bgv));

        if (rst) begin
            model_reset();
        end else begin
            m_rd_pend = e_rd & req_rd;
            m_wr_pend = e_wr & req_wr;
            if (x_restart != '0) begin
                m_va = addr_of(m_rd_ch);
                m_left = LAT;
            end else if (m_left == 0 || pre) begin
                ww = first_set(e_wr);
                wr = first_set(e_rd);
                m_latch = '0; m_rd_ch = -1; m_bg = 0;
                m_nrd = 1'b1; m_nwr = 1'b1; m_left = 0;
                if (ww >= 0) begin
                    m_nwr = 1'b0; m_va = addr_of(ww); m_vd = req_wdata[ww*DW +: DW];
                    m_left = LAT; m_wr_pend[ww] = 1'b0;
                end else if (wr >= 0) begin
                    m_nrd = 1'b0; m_va = addr_of(wr); m_rd_ch = wr; m_latch[wr] = 1'b1;
                    m_left = LAT; m_rd_pend[wr] = 1'b0;
                end else if (bg_req) begin
                    m_nrd = 1'b0; m_va = bg_addr; m_bg = 1; m_left = LBG;
                end
            end else begin
                m_left--;
            end
        end
        m_rd_prev = req_rd;
        m_wr_prev = req_wr;
        @(posedge clk28);
        @(negedge clk28);
    endtask

    task automatic drain();
        req_rd = '0; req_wr = '0; bg_req = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        rst = 1'b1; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        bg_req = 1'b0; bg_addr = '0;
        @(posedge clk28);
        @(negedge clk28);
        model_reset();
        m_rd_prev = req_rd; m_wr_prev = req_wr;
        tick();
        tick();
        rst = 1'b0;
        drain();

        // Simultaneous write ch0 and read ch1: write first, then the read.
        req_wr[0] = 1'b1; req_rd[1] = 1'b1;
        set_addr(0, 19'h00100); set_addr(1, 19'h00200); req_wdata[7:0] = 8'h5A;
        tick();
        #1 check("s030_wr_n_vwr", 32'(n_vwr), 32'd0);
        tick(); tick(); tick();
        #1 check("s030_rd_va", 32'(va), 32'h00200);
        tick(); tick();
        #1 check("s030_rd_valid", 32'(req_valid[1]), 32'd1);
        tick();
        drain();

        // Address change during a ch0 read restarts it.
        req_rd[0] = 1'b1; set_addr(0, 19'h04000);
        tick(); tick();
        set_addr(0, 19'h0C000);
        #1 check("s031_restart", 32'(req_restart[0]), 32'd1);
        tick();
        #1 check("s031_va", 32'(va), 32'h0C000);
        tick(); tick();
        #1 check("s031_valid", 32'(req_valid[0]), 32'd1);
        tick();
        drain();

        // Channel read arriving during the last background cycle.
        bg_req = 1'b1; bg_addr = 19'h7A000;
        tick();
        req_rd[0] = 1'b1; set_addr(0, 19'h01000);
`ifdef RAM_ARB_PREEMPT_EN
        #1 check("s032_no_ack", 32'(bg_ack), 32'd0);
        tick();
        bg_req = 1'b0;
        #1 check("s032_rd_grant", 32'(n_vrd) | (32'(va) << 1), 32'h01000 << 1);
        tick();
`else
        #1 check("s033_ack", 32'(bg_ack), 32'd1);
        tick();
        bg_req = 1'b0;
        #1 check("s033_bg_valid", 32'(bg_valid), 32'd1);
        tick();
        #1 check("s033_rd_va", 32'(va), 32'h01000);
        tick();
`endif
        drain();

        // A ch1 read that drops before a grant point is cancelled while ch0 writes back to back.
        seen = 1'b0;
        set_addr(0, 19'h00300); set_addr(1, 19'h00400);
        for (int k = 0; k < 15; k++) begin
            req_wr[0] = (k % 3) != 2;
            req_rd[1] = (k == 1);
            #1 seen |= req_latchen[1];
            tick();
        end
        req_wr = '0;
        for (int k = 0; k < 6; k++) begin
            #1 seen |= req_latchen[1];
            tick();
        end
        check("s034_ch1_never", 32'(seen), 32'd0);
        drain();

        // Reset mid-read with the request held: no grant until the request toggles.
        req_rd[0] = 1'b1; set_addr(0, 19'h02000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 check("s035_idle", 32'(n_vrd), 32'd1);
            tick();
        end
        req_rd[0] = 1'b0; tick();
        req_rd[0] = 1'b1; tick();
        #1 check("s035_regrant", 32'(n_vrd), 32'd0);
        tick();
        drain();

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 3) == 0) req_rd[i] = ~req_rd[i];
                if ($urandom_range(0, 5) == 0) req_wr[i] = ~req_wr[i];
                if ($urandom_range(0, 7) == 0) set_addr(i, AW'($urandom_range(0, 3) << 12) | AW'(i << 8));
                req_wdata[i*DW +: DW] = DW'($urandom);
            end
            if ($urandom_range(0, 3) == 0) bg_req = ~bg_req;
            if ($urandom_range(0, 3) == 0) bg_addr = AW'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
